// File: rtl/traffic_light_hex_driver.sv
// Seven-segment display stage for the traffic-light HEX PIO byte: hex decode,
// blanking, two-rate blinking and a power-on lamp test, all outputs registered.
module traffic_light_hex_driver #(
  parameter int TICK_DIV        = 6_250_000,
  parameter int LAMP_TEST_TICKS = 8,
  parameter int SLOW_DIV        = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_port,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic       lamp_test,
  output logic       blink_phase
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int LW = (LAMP_TEST_TICKS > 0) ? $clog2(LAMP_TEST_TICKS + 1) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SLOW_LAST  = SW'(SLOW_DIV - 1);
  localparam logic [LW-1:0] LAMP_LAST  = LW'(LAMP_TEST_TICKS - 1);

  typedef enum logic {
    ST_LAMP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [LW-1:0]   lamp_cnt, lamp_cnt_nxt;
  logic [PW-1:0]   presc;
  logic [SW-1:0]   slow_cnt;
  logic [7:0]      in_q;
  logic            en_d;
  logic            rate_d;
  logic            tick;
  logic            blink_rise;
  logic            rate_chg;
  logic [6:0]      seg_d;
  logic            dp_d;
  logic            lamp_d;

  // Active-low hex font, segment a on bit 0.
  function automatic logic [6:0] hex_font(input logic [3:0] digit);
    logic [6:0] f;
    case (digit)
      4'h0: f = 7'b1000000;
      4'h1: f = 7'b1111001;
      4'h2: f = 7'b0100100;
      4'h3: f = 7'b0110000;
      4'h4: f = 7'b0011001;
      4'h5: f = 7'b0010010;
      4'h6: f = 7'b0000010;
      4'h7: f = 7'b1111000;
      4'h8: f = 7'b0000000;
      4'h9: f = 7'b0010000;
      4'hA: f = 7'b0001000;
      4'hB: f = 7'b0000011;
      4'hC: f = 7'b1000110;
      4'hD: f = 7'b0100001;
      4'hE: f = 7'b0000110;
      default: f = 7'b0001110;
    endcase
    return f;
  endfunction

  // Stage p0: input capture and edge-detect history
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      in_q   <= 8'h00;
      en_d   <= 1'b0;
      rate_d <= 1'b0;
    end else begin
      in_q   <= in_port;
      en_d   <= in_q[5];
      rate_d <= in_q[6];
    end
  end

  assign blink_rise = in_q[5] & ~en_d;
  assign rate_chg   = in_q[6] ^ rate_d;

  assign tick = (presc == PRESC_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Enable edge outranks rate change, which outranks a tick, so a fresh
  // blink always starts visible and a rate switch never toggles by itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blink_phase <= 1'b1;
      slow_cnt    <= '0;
    end else if (!in_q[5] || blink_rise) begin
      blink_phase <= 1'b1;
      slow_cnt    <= '0;
    end else if (rate_chg) begin
      slow_cnt    <= '0;
    end else if (tick) begin
      if (in_q[6]) begin
        blink_phase <= ~blink_phase;
      end else if (slow_cnt == SLOW_LAST) begin
        slow_cnt    <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        slow_cnt    <= slow_cnt + SW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= (LAMP_TEST_TICKS > 0) ? ST_LAMP : ST_RUN;
      lamp_cnt <= '0;
    end else begin
      state    <= state_nxt;
      lamp_cnt <= lamp_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    lamp_cnt_nxt = lamp_cnt;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    lamp_d       = 1'b0;
    case (state)
      ST_LAMP: begin
        seg_d  = 7'h00;
        dp_d   = 1'b0;
        lamp_d = 1'b1;
        if (tick) begin
          if (lamp_cnt == LAMP_LAST) begin
            state_nxt = ST_RUN;
          end else begin
            lamp_cnt_nxt = lamp_cnt + LW'(1);
          end
        end
      end
      ST_RUN: begin
        if (!in_q[4] && !(in_q[5] && !blink_phase)) begin
          seg_d = hex_font(in_q[3:0]);
          dp_d  = ~in_q[7];
        end
      end
      default: ;
    endcase
  end

  // Stage p1: output register, every pin driven straight from a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      seg_n     <= 7'h7F;
      dp_n      <= 1'b1;
      lamp_test <= 1'b0;
    end else begin
      seg_n     <= seg_d;
      dp_n      <= dp_d;
      lamp_test <= lamp_d;
    end
  end

endmodule
